// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state type and divisor helper for the
// UART receive path (and the baud prescaler it shares with the transmitter).
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned OS        = 16;

  // Oversample ticks on which the line is sampled for the 2-of-3 vote;
  // the bit value is decided on OS_V2.
  localparam logic [3:0] OS_V0 = 4'd7;
  localparam logic [3:0] OS_V1 = 4'd8;
  localparam logic [3:0] OS_V2 = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  // Clocks per oversample tick, floored at 2 so the prescaler always counts.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * OS);
    return (d < 2) ? 2 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: prescaler producing a one-cycle tick every DIV clocks.
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   i_restart in   synchronous restart: counter returns to 0, no tick
//   o_tick    out  one-cycle pulse when the counter reaches DIV-1
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_restart || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver, 16x oversampling, mid-bit 2-of-3 vote,
// one-entry valid/ready output register.
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   rx        in   serial line, idle high, asynchronous to clk
//   rx_data   out  received byte, stable while rx_valid=1
//   rx_valid  out  byte available, held until rx_valid & rx_ready
//   rx_ready  in   consumer accepts the byte
//   frame_err out  one-cycle pulse: stop bit voted 0
//   overrun   out  one-cycle pulse: completed byte dropped, register full
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic       r_sync1;
  logic       r_rxs;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_os_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_s7;
  logic       r_s8;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_frame_err;
  logic       r_overrun;

  logic w_tick;
  logic w_restart;
  logic w_vote_now;
  logic w_bit;
  logic w_shift_en;
  logic w_byte_done;
  logic w_ferr;

  // 2-flop synchronizer, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

  assign w_vote_now = w_tick && (r_os_cnt == OS_V2);
  assign w_bit      = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_shift_en  = 1'b0;
    w_byte_done = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_rxs) begin
          w_restart   = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_vote_now) begin
          w_state_nxt = w_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_vote_now) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        // Leave mid stop bit so the next start edge is seen even with no gap.
        if (w_vote_now) begin
          if (w_bit) begin
            w_byte_done = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (r_rxs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit-timing datapath: os_cnt parked at 0 in IDLE so it starts aligned
  // with the tick restart issued on the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_s7      <= 1'b1;
      r_s8      <= 1'b1;
    end else begin
      if (r_state == IDLE) begin
        r_os_cnt <= '0;
      end else if (w_tick) begin
        r_os_cnt <= r_os_cnt + 1'b1;
      end

      if (w_tick && r_os_cnt == OS_V0) begin
        r_s7 <= r_rxs;
      end
      if (w_tick && r_os_cnt == OS_V1) begin
        r_s8 <= r_rxs;
      end

      if (r_state == START) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (w_shift_en) begin
        r_shift <= {w_bit, r_shift[7:1]};
      end
    end
  end

  // One-entry output register; a same-cycle handshake frees the slot for
  // the incoming byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (w_byte_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
